// File: rtl/ad7606_avg_streamer.sv
// Averages 2^LOG2_AVG AD7606 frames per channel and streams the eight results over valid/ready.
// Define AVG_FRAME_HEADER_EN to prefix each block with a {8'hA5, seq} header word.
`timescale 1ns/1ps

module ad7606_avg_streamer #(
    parameter int LOG2_AVG = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ad_ch1_i,
    input  logic [15:0] ad_ch2_i,
    input  logic [15:0] ad_ch3_i,
    input  logic [15:0] ad_ch4_i,
    input  logic [15:0] ad_ch5_i,
    input  logic [15:0] ad_ch6_i,
    input  logic [15:0] ad_ch7_i,
    input  logic [15:0] ad_ch8_i,
    input  logic        ad_valid_i,
    output logic [15:0] m_data_o,
    output logic [3:0]  m_chan_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic        drop_o
);

    localparam int AW = 16 + LOG2_AVG;
    localparam int FW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [FW-1:0] FCNT_MAX = FW'((1 << LOG2_AVG) - 1);

`ifdef AVG_FRAME_HEADER_EN
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEND} state_t;
    localparam state_t S_FIRST = S_HDR;
    logic [7:0] seq_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
    localparam state_t S_FIRST = S_SEND;
`endif

    state_t state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [FW-1:0] fcnt_q;
    logic signed [AW-1:0] acc_q [8];
    logic signed [AW-1:0] sum [8];
    logic signed [15:0] ch [8];
    logic [15:0] avg [8];
    logic [15:0] obuf_q [8];
    logic obuf_full_q;
    logic drop_q;
    logic complete, last_hs, load;

    always_comb begin
        ch[0] = ad_ch1_i;
        ch[1] = ad_ch2_i;
        ch[2] = ad_ch3_i;
        ch[3] = ad_ch4_i;
        ch[4] = ad_ch5_i;
        ch[5] = ad_ch6_i;
        ch[6] = ad_ch7_i;
        ch[7] = ad_ch8_i;
        // Sum of 2^LOG2_AVG sign-extended samples fits AW bits, so the shifted result fits 16.
        for (int n = 0; n < 8; n++) begin
            sum[n] = acc_q[n] + AW'(ch[n]);
            avg[n] = 16'(sum[n] >>> LOG2_AVG);
        end
    end

    assign complete = ad_valid_i && (fcnt_q == FCNT_MAX);
    assign last_hs  = (state_q == S_SEND) && (idx_q == 3'd7) && m_ready_i;
    assign load     = complete && (!obuf_full_q || last_hs);
    assign drop_o   = drop_q;

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        m_data_o  = 16'h0000;
        m_chan_o  = 4'h0;
        m_valid_o = 1'b0;
        m_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (obuf_full_q) begin
                    state_d = S_FIRST;
                    idx_d   = 3'd0;
                end
            end
`ifdef AVG_FRAME_HEADER_EN
            S_HDR: begin
                m_valid_o = 1'b1;
                m_data_o  = {8'hA5, seq_q};
                m_chan_o  = 4'hF;
                if (m_ready_i) begin
                    state_d = S_SEND;
                    idx_d   = 3'd0;
                end
            end
`endif
            S_SEND: begin
                m_valid_o = 1'b1;
                m_data_o  = obuf_q[idx_q];
                m_chan_o  = {1'b0, idx_q};
                m_last_o  = (idx_q == 3'd7);
                if (m_ready_i) begin
                    if (idx_q == 3'd7) begin
                        state_d = load ? S_FIRST : S_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            fcnt_q      <= '0;
            obuf_full_q <= 1'b0;
            drop_q      <= 1'b0;
            // NOTE: the small accumulator and output arrays are reset so a partial block never leaks out.
            for (int n = 0; n < 8; n++) begin
                acc_q[n]  <= '0;
                obuf_q[n] <= 16'h0000;
            end
`ifdef AVG_FRAME_HEADER_EN
            seq_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= complete && !load;
            if (ad_valid_i) begin
                for (int n = 0; n < 8; n++) acc_q[n] <= complete ? '0 : sum[n];
                fcnt_q <= complete ? '0 : fcnt_q + FW'(1);
            end
            if (load) begin
                for (int n = 0; n < 8; n++) obuf_q[n] <= avg[n];
                obuf_full_q <= 1'b1;
            end else if (last_hs) begin
                obuf_full_q <= 1'b0;
            end
`ifdef AVG_FRAME_HEADER_EN
            if (state_q == S_HDR && m_ready_i) seq_q <= seq_q + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_ad7606_avg_streamer.sv
// Directed bench for ad7606_avg_streamer (LOG2_AVG=2); header checks run when AVG_FRAME_HEADER_EN is defined.
`timescale 1ns/1ps

module tb_ad7606_avg_streamer;

`ifdef AVG_FRAME_HEADER_EN
    localparam int WPB = 9;
    localparam logic [3:0] FIRST_CHAN = 4'hF;
`else
    localparam int WPB = 8;
    localparam logic [3:0] FIRST_CHAN = 4'h0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic [15:0] ad_ch [8];
    logic ad_valid, m_ready;
    logic [15:0] m_data;
    logic [3:0] m_chan;
    logic m_valid, m_last, drop;

    int n_vec = 0;
    int n_err = 0;
    int drop_cnt = 0;
    logic [15:0] q_data [$];
    logic [3:0]  q_chan [$];
    logic        q_last [$];
    logic [15:0] q_hdr  [$];
    logic [21:0] prev_out;
    logic prev_stall = 1'b0;

    ad7606_avg_streamer #(.LOG2_AVG(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .ad_ch1_i(ad_ch[0]), .ad_ch2_i(ad_ch[1]), .ad_ch3_i(ad_ch[2]), .ad_ch4_i(ad_ch[3]),
        .ad_ch5_i(ad_ch[4]), .ad_ch6_i(ad_ch[5]), .ad_ch7_i(ad_ch[6]), .ad_ch8_i(ad_ch[7]),
        .ad_valid_i(ad_valid),
        .m_data_o(m_data), .m_chan_o(m_chan), .m_valid_o(m_valid), .m_last_o(m_last),
        .m_ready_i(m_ready), .drop_o(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Collects handshaken words and checks outputs hold while stalled.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold", {m_valid, m_last, m_chan, m_data}, prev_out);
            if (m_valid && m_ready) begin
                if (m_chan == 4'hF) q_hdr.push_back(m_data);
                else begin
                    q_data.push_back(m_data);
                    q_chan.push_back(m_chan);
                    q_last.push_back(m_last);
                end
            end
            if (drop) drop_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_valid, m_last, m_chan, m_data};
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, observed no end expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_valid(input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] cr);
        @(posedge clk); #1;
        ad_ch[0] = c1;
        ad_ch[1] = c2;
        for (int n = 2; n < 8; n++) ad_ch[n] = cr;
        ad_valid = 1'b1;
        @(posedge clk); #1;
        ad_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] c1, input logic [15:0] c2, input logic [15:0] cr);
        drive_valid(c1, c2, cr);
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic check_block(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                               input logic [15:0] er);
        logic [15:0] exp;
        check({tag, "_avail"}, 32'(q_data.size() >= 8), 32'd1);
        if (q_data.size() < 8) return;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 0) ? e1 : (i == 1) ? e2 : er;
            check({tag, "_data"}, 32'(q_data.pop_front()), 32'(exp));
            check({tag, "_chan"}, 32'(q_chan.pop_front()), 32'(i));
            check({tag, "_last"}, 32'(q_last.pop_front()), 32'(i == 7));
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        ad_valid = 1'b0;
        m_ready  = 1'b1;
        for (int n = 0; n < 8; n++) ad_ch[n] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(m_data), 32'h0);
        check("rst_chan", 32'(m_chan), 32'h0);
        check("rst_valid", 32'(m_valid), 32'h0);
        check("rst_last", 32'(m_last), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        reset_n = 1'b1;

        // Basic average, negative rounding, positive full scale.
        send_frame(16'd100, 16'hFFFF, 16'h7FFF);
        send_frame(16'd102, 16'hFFFE, 16'h7FFF);
        send_frame(16'd104, 16'hFFFE, 16'h7FFF);
        send_frame(16'd106, 16'hFFFE, 16'h7FFF);
        repeat (4) @(posedge clk);
        #1;
        check_block("avg", 16'd103, 16'hFFFE, 16'h7FFF);
        check("avg_extra", 32'(q_data.size()), 32'd0);

        // Negative full scale, plus one-cycle output latency.
        repeat (3) send_frame(16'h8000, 16'h8000, 16'h8000);
        drive_valid(16'h8000, 16'h8000, 16'h8000);
        check("lat_valid_lo", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_hi", 32'(m_valid), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check_block("min", 16'h8000, 16'h8000, 16'h8000);

        // Backpressure: second block completes while the first is stalled and is dropped.
        drop_cnt = 0;
        repeat (3) send_frame(16'h0010, 16'h0020, 16'h0030);
        drive_valid(16'h0010, 16'h0020, 16'h0030);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        repeat (8) @(posedge clk);
        repeat (4) send_frame(16'h0100, 16'h0200, 16'h0300);
        repeat (3) @(posedge clk);
        #1;
        check("bp_valid_held", 32'(m_valid), 32'd1);
        check("bp_drop_cnt", 32'(drop_cnt), 32'd1);
        m_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_block("bp", 16'h0010, 16'h0020, 16'h0030);
        check("bp_extra", 32'(q_data.size()), 32'd0);
        check("bp_drop_final", 32'(drop_cnt), 32'd1);

        // Final handshake coincides with the next block completing.
        drop_cnt = 0;
        m_ready = 1'b0;
        repeat (3) send_frame(16'h0005, 16'hFFF0, 16'h1234);
        drive_valid(16'h0005, 16'hFFF0, 16'h1234);
        repeat (9) @(posedge clk);
        repeat (3) send_frame(16'h0200, 16'h0300, 16'h0400);
        m_ready = 1'b1;
        repeat (WPB - 2) @(posedge clk);
        drive_valid(16'h0200, 16'h0300, 16'h0400);
        check("bb_drop", 32'(drop), 32'd0);
        check("bb_valid", 32'(m_valid), 32'd1);
        check("bb_chan", 32'(m_chan), 32'(FIRST_CHAN));
        repeat (12) @(posedge clk);
        #1;
        check("bb_drop_cnt", 32'(drop_cnt), 32'd0);
        check_block("bb_a", 16'h0005, 16'hFFF0, 16'h1234);
        check_block("bb_b", 16'h0200, 16'h0300, 16'h0400);

        // Reset mid-block discards the partial accumulation.
        send_frame(16'd500, 16'd500, 16'd500);
        send_frame(16'd500, 16'd500, 16'd500);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mr_data", 32'(m_data), 32'h0);
        check("mr_chan", 32'(m_chan), 32'h0);
        check("mr_valid", 32'(m_valid), 32'h0);
        check("mr_last", 32'(m_last), 32'h0);
        check("mr_drop", 32'(drop), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) send_frame(16'd10, 16'd10, 16'd10);
        repeat (4) @(posedge clk);
        #1;
        check_block("mr", 16'd10, 16'd10, 16'd10);
        check("mr_extra", 32'(q_data.size()), 32'd0);

`ifdef AVG_FRAME_HEADER_EN
        // Sequence number wraps after 256 headers.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        q_hdr.delete();
        q_data.delete();
        q_chan.delete();
        q_last.delete();
        for (int b = 0; b < 257; b++) repeat (4) send_frame(16'(b), 16'd1, 16'd2);
        repeat (12) @(posedge clk);
        #1;
        check("hdr_count", 32'(q_hdr.size()), 32'd257);
        check("hdr_words", 32'(q_data.size()), 32'd2056);
        for (int i = 0; i < q_hdr.size(); i++) check("hdr_value", 32'(q_hdr[i]), 32'(16'hA500 | (i % 256)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ad7606_avg_streamer.md
# ad7606_avg_streamer

Downstream stage of the AD7606 capture block. It consumes each completed 8-channel frame, marked by that block's one-cycle data-valid pulse, and averages 2^LOG2_AVG consecutive frames per channel. It then streams the eight averaged words, one per handshake, over a valid/ready interface toward the packet/DMA logic. A one-deep output buffer lets the next average accumulate while the previous one drains.

## Interface
- LOG2_AVG, 2, log2 of frames averaged per output block; legal 0..4 (1..16 frames)
- clk  input  1  system clock, same domain as the AD7606 capture block
- reset_n  input  1  asynchronous, active-low reset
- ad_ch1_i … ad_ch8_i  input  16 each  channel samples, two's complement, stable while ad_valid_i high
- ad_valid_i  input  1  one-cycle pulse: new frame present on ad_chN_i
- m_data_o  output  16  output word (averaged sample, or header)
- m_chan_o  output  4  channel index 0..7 of m_data_o; 4'hF for header
- m_valid_o  output  1  m_data_o/m_chan_o/m_last_o valid
- m_last_o  output  1  high on the channel-7 word of a block
- m_ready_i  input  1  downstream accepts the word when m_valid_o && m_ready_i
- drop_o  output  1  one-cycle pulse: a completed block was discarded (buffer busy)

## Operation
- Accumulators acc[0..7] are signed, 16+LOG2_AVG bits. Each input is sign-extended before it is added. Frame counter fcnt is LOG2_AVG bits wide.
- On ad_valid_i with fcnt < 2^LOG2_AVG−1: acc[n] += ad_chn_i; fcnt++.
- On ad_valid_i with fcnt = 2^LOG2_AVG−1 (block complete):
  - res[n] = (acc[n] + ad_chn_i) >>> LOG2_AVG, using an arithmetic shift (rounds toward −inf). The result always fits in 16 bits, so no saturation logic is needed.
  - acc[n] is cleared to 0 and fcnt is cleared to 0, regardless of whether the block is kept.
  - If the output buffer is free, or is freed by the final handshake in the same cycle, res[] loads into the buffer and the block is marked full.
  - Otherwise res[] is discarded and drop_o pulses for one cycle.
- LOG2_AVG=0: every frame is a complete block.
- Output FSM states are IDLE, HDR (only with the macro) and SEND; idx is 3 bits.
  - IDLE: when the buffer is full, go to HDR (or SEND with idx=0).
  - HDR: m_valid_o=1. On handshake, go to SEND with idx=0.
  - SEND: m_data_o=buf[idx], m_chan_o=idx, m_last_o=(idx==7).
    - On handshake with idx<7: idx++.
    - On handshake with idx==7: mark the buffer free and go to IDLE.
    - If a new block loads in that same cycle, go directly to HDR/SEND with idx=0 instead.
- Stream rule: while m_valid_o && !m_ready_i, all m_* outputs hold stable. m_valid_o never drops without a handshake.
- Reset (any time, including mid-block or mid-stream) clears all accumulators, counters, the buffer, the sequence number and the FSM. A partially accumulated block is lost.

## Timing
- Reset values:
  - m_data_o=0, m_chan_o=0, m_valid_o=0, m_last_o=0, drop_o=0.
  - FSM in IDLE, buffer free, fcnt=0, seq=0.
- Latency: m_valid_o rises on the edge after the clock edge that samples the completing ad_valid_i. That is one cycle, and only when the FSM is IDLE.
- Throughput: one word per cycle with m_ready_i held high. A block drains in 8 cycles, or 9 with the header.
- ad_valid_i pulses arrive at least 9 cycles apart. A complete block can never be overwritten in the buffer; it is either kept or dropped.
- drop_o is asserted in the cycle after the completing ad_valid_i.

## Configuration
- AVG_FRAME_HEADER_EN defined:
  - Each block is preceded by a header word: m_data_o = {8'hA5, seq[7:0]}, m_chan_o=4'hF, m_last_o=0.
  - seq increments after each emitted header and wraps 255→0.
  - Dropped blocks do not consume a sequence number.
- AVG_FRAME_HEADER_EN undefined: HDR state and seq are absent; a block is exactly 8 words.

## Test plan
- LOG2_AVG=2, m_ready_i=1, ch1 frames 100,102,104,106 -> one block, m_chan_o=0 word = 103, eight words total, m_last_o only on chan 7.
- LOG2_AVG=2, ch2 frames −1,−2,−2,−2 (0xFFFF,0xFFFE×3) -> chan 1 word = 0xFFFE (−7>>>2 = −2); all 0x7FFF -> 0x7FFF; all 0x8000 -> 0x8000.
- Backpressure: m_ready_i=0 after the first word while a second block completes -> m_* held stable, drop_o pulses once, exactly one 8-word block emitted after m_ready_i returns.
- Final handshake (chan 7) in the same cycle a new block completes -> no drop_o, next block's first word valid on the following cycle.
- reset_n asserted low after 2 of 4 frames, then 4 fresh frames of 10 -> output word 10, no contribution from pre-reset frames, all outputs at reset values while reset_n low.
- With AVG_FRAME_HEADER_EN: 257 consecutive blocks -> headers 0xA500…0xA5FF then 0xA500, m_chan_o=4'hF on each header.
